// File: rtl/memory_pkg.sv
// Shared constants and enums for the word-storage block of the process-in-memory datapath.
// Default geometry is 1024 x 32 with a two-cycle access latency.
package memory_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 32;
    localparam int LATENCY_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/memory_array.sv
// 2^ADDR_W x DATA_W storage: synchronous write, registered read, no reset.
// rdata shows the word at the address presented on the previous edge.
module memory_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule

// File: rtl/memory.sv
// Single-port word memory with request/ready handshake; one access per LATENCY+2 cycles.
// Commit and ready happen LATENCY edges after acceptance; requests during BUSY/DONE are ignored.
module memory
    import memory_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write,
    input  logic              read,
    output logic [DATA_W-1:0] data_out,
    output logic              ready
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    op_t               r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_data_out;
    logic              r_ready;

    logic              w_accept;
    logic              w_commit;
    logic              w_we;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [DATA_W-1:0] w_rdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (write || read) begin
                    w_accept    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The array read is launched from the live address while idle so that even
    // LATENCY=1 has the registered read word available at the commit edge.
    assign w_arr_addr = (r_state == IDLE) ? address : r_addr;
    assign w_we       = w_commit && (r_op == OP_WRITE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op       <= OP_READ;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_data_out <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_ready <= w_commit;
            if (w_accept) begin
                r_op    <= write ? OP_WRITE : OP_READ;
                r_addr  <= address;
                r_wdata <= data_in;
                r_cnt   <= CNT_W'(LATENCY);
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_commit && (r_op == OP_READ)) begin
                r_data_out <= w_rdata;
            end
        end
    end

    memory_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock (clock),
        .we    (w_we),
        .addr  (w_arr_addr),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    assign data_out = r_data_out;
    assign ready    = r_ready;

endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: a timeline model predicts ready/data_out every cycle,
// and literal expectations pin the key cycles of each scenario.
module tb_memory;

    localparam int LAT = 2;

    logic        clock;
    logic        reset_n;
    logic [9:0]  address;
    logic [31:0] data_in;
    logic        write;
    logic        read;
    logic [31:0] data_out;
    logic        ready;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned ready_cnt   = 0;

    memory #(
        .ADDR_W  (10),
        .DATA_W  (32),
        .LATENCY (LAT)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .address  (address),
        .data_in  (data_in),
        .write    (write),
        .read     (read),
        .data_out (data_out),
        .ready    (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: dut=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: an access accepted at edge t completes at t+LAT and the
    // next acceptance is possible no earlier than t+LAT+2.
    int unsigned t_edge    = 0;
    int unsigned m_done_at = 0;
    int unsigned m_free_at = 0;
    bit          m_pend    = 1'b0;
    bit          m_wr      = 1'b0;
    logic [9:0]  m_addr    = '0;
    logic [31:0] m_data    = '0;
    logic [31:0] m_mem [int];
    logic [31:0] exp_data  = '0;
    logic        exp_ready = 1'b0;

    always @(posedge clock) begin
        if (reset_n) begin
            t_edge++;
            exp_ready = 1'b0;
            if (m_pend && t_edge == m_done_at) begin
                if (m_wr) m_mem[int'(m_addr)] = m_data;
                else      exp_data = m_mem[int'(m_addr)];
                exp_ready = 1'b1;
                m_pend    = 1'b0;
            end
            if (!m_pend && t_edge >= m_free_at && (write || read)) begin
                m_pend    = 1'b1;
                m_wr      = write;
                m_addr    = address;
                m_data    = data_in;
                m_done_at = t_edge + LAT;
                m_free_at = t_edge + LAT + 2;
            end
        end
    end

    always @(negedge reset_n) begin
        m_pend    = 1'b0;
        exp_ready = 1'b0;
        exp_data  = '0;
        m_free_at = 0;
    end

    always @(negedge clock) begin
        chk("model_ready", {31'b0, ready}, {31'b0, exp_ready});
        chk("model_data_out", data_out, exp_data);
        if (ready) ready_cnt++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input bit wr, input logic [9:0] a, input logic [31:0] d);
        address = a;
        data_in = d;
        write   = wr;
        read    = !wr;
        step();
        write = 1'b0;
        read  = 1'b0;
        repeat (LAT) step();
        step();
    endtask

    initial begin
        int unsigned cnt0;
        reset_n = 1'b1;
        address = '0;
        data_in = '0;
        write   = 1'b0;
        read    = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) step();
        @(negedge clock);
        chk("reset_ready", {31'b0, ready}, 32'h0);
        chk("reset_data_out", data_out, 32'h0000_0000);
        reset_n = 1'b1;

        // Write then read of address 0 with cycle-exact ready timing
        address = 10'h000;
        data_in = 32'hFA35_0123;
        write   = 1'b1;
        step();
        write = 1'b0;
        @(negedge clock) chk("wr_e0_ready", {31'b0, ready}, 32'h0);
        step();
        @(negedge clock) chk("wr_e1_ready", {31'b0, ready}, 32'h0);
        step();
        @(negedge clock) chk("wr_e2_ready", {31'b0, ready}, 32'h1);
        step();
        @(negedge clock) chk("wr_e3_ready", {31'b0, ready}, 32'h0);
        read = 1'b1;
        repeat (3) step();
        read = 1'b0;
        @(negedge clock);
        chk("rd0_ready", {31'b0, ready}, 32'h1);
        chk("rd0_data", data_out, 32'hFA35_0123);
        step();
        step();
        @(negedge clock);
        chk("rd0_hold_data", data_out, 32'hFA35_0123);
        chk("rd0_hold_ready", {31'b0, ready}, 32'h0);

        // Write wins over read; data_out untouched by the write
        address = 10'h3FF;
        data_in = 32'h1234_5678;
        write   = 1'b1;
        read    = 1'b1;
        step();
        write = 1'b0;
        read  = 1'b0;
        step();
        step();
        @(negedge clock);
        chk("prio_ready", {31'b0, ready}, 32'h1);
        chk("prio_data_unchanged", data_out, 32'hFA35_0123);
        step();
        do_op(1'b0, 10'h3FF, 32'h0);
        chk("prio_readback", data_out, 32'h1234_5678);

        // Independent addresses
        do_op(1'b1, 10'h001, 32'hAAAA_5555);
        do_op(1'b1, 10'h002, 32'h5555_AAAA);
        do_op(1'b1, 10'h005, 32'h1111_1111);
        do_op(1'b0, 10'h001, 32'h0);
        chk("indep_rd1", data_out, 32'hAAAA_5555);
        do_op(1'b0, 10'h002, 32'h0);
        chk("indep_rd2", data_out, 32'h5555_AAAA);

        // Held read: pulses every LAT+2 edges, busy-time input changes ignored
        cnt0 = ready_cnt;
        for (int i = 0; i < 16; i++) begin
            read    = 1'b1;
            address = (i % 4 == 0) ? 10'h001 : 10'h002;
            write   = (i % 4 == 1);
            data_in = 32'hBAD0_0000 + i;
            step();
        end
        read  = 1'b0;
        write = 1'b0;
        chk("held_pulses", ready_cnt - cnt0, 32'd4);
        chk("held_data", data_out, 32'hAAAA_5555);
        do_op(1'b0, 10'h002, 32'h0);
        chk("held_no_write", data_out, 32'h5555_AAAA);

        // Reset during an in-flight write aborts it
        address = 10'h005;
        data_in = 32'hDEAD_BEEF;
        write   = 1'b1;
        step();
        write   = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        chk("abort_ready", {31'b0, ready}, 32'h0);
        chk("abort_data_out", data_out, 32'h0);
        step();
        step();
        reset_n = 1'b1;
        @(negedge clock) chk("abort_ready_post", {31'b0, ready}, 32'h0);
        step();
        do_op(1'b0, 10'h005, 32'h0);
        chk("abort_readback", data_out, 32'h1111_1111);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, dut=running expected=finished");
        $fatal(1);
    end

endmodule
